// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: controller state encoding and the
// bubble value loaded into a flushed pipeline register.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MDU_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] m;
      logic [3:0] ex;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the register load/flush
// controls returned to it.
interface pipe_hazard_ctrl_if;

   logic [4:0] ifid_rs;
   logic [4:0] ifid_rt;
   logic       ifid_uses_rt;
   logic       idex_memread;
   logic [4:0] idex_rt;
   logic       branch_taken;
   logic       mem_req;
   logic       mem_ready;
   logic       mdu_start;
   logic       mdu_done;

   logic       pc_we;
   logic       ifid_we;
   logic       idex_we;
   logic       exmem_we;
   logic       memwb_we;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_flush;
   logic       memwb_flush;

   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt,
      output idex_memread, idex_rt, branch_taken,
      output mem_req, mem_ready, mdu_start, mdu_done,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
      input  ifid_flush, idex_flush, exmem_flush, memwb_flush
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt,
      input  idex_memread, idex_rt, branch_taken,
      input  mem_req, mem_ready, mdu_start, mdu_done,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
      output ifid_flush, idex_flush, exmem_flush, memwb_flush
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the sources of the
// instruction in ID; r0 never creates a dependency.
module hazard_detect (
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       ifid_uses_rt,
   input  logic       idex_memread,
   input  logic [4:0] idex_rt,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = (idex_rt == ifid_rs);
   assign rt_hit = ifid_uses_rt && (idex_rt == ifid_rt);

   assign load_use = idex_memread && (idex_rt != 5'd0)
                     && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: post-reset flush, load-use,
// branch squash, memory wait and MDU wait with timeout.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int MDU_MAX     = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_hazard_ctrl_if.slave hz,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mdu_timeout
);

   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int TW = $clog2(MDU_MAX + 1);

   localparam logic [1:0] S_INIT = ST_INIT;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_MDU  = ST_MDU_WAIT;

   logic [1:0]    state;
   logic [IW-1:0] init_cnt;
   logic [TW-1:0] mdu_tmr;

   logic load_use;
   logic mem_wait;
   logic mdu_go;
   logic mdu_last;
   logic pc_we;

   hazard_detect u_hd (
      .ifid_rs      (hz.ifid_rs),
      .ifid_rt      (hz.ifid_rt),
      .ifid_uses_rt (hz.ifid_uses_rt),
      .idex_memread (hz.idex_memread),
      .idex_rt      (hz.idex_rt),
      .load_use     (load_use)
   );

   assign mem_wait = hz.mem_req && !hz.mem_ready;
   assign mdu_go   = hz.mdu_done && !mem_wait;
   assign mdu_last = (mdu_tmr == TW'(MDU_MAX - 1));

   always_comb begin
      pc_we          = 1'b1;
      hz.ifid_we     = 1'b1;
      hz.idex_we     = 1'b1;
      hz.exmem_we    = 1'b1;
      hz.memwb_we    = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.memwb_flush = 1'b0;
      case (state)
         S_RUN: begin
            if (mem_wait) begin
               pc_we          = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_we     = 1'b0;
               hz.exmem_we    = 1'b0;
               hz.memwb_flush = 1'b1;
            end else if (hz.mdu_start) begin
               pc_we          = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_we     = 1'b0;
               hz.exmem_flush = 1'b1;
            end else if (hz.branch_taken) begin
               hz.ifid_flush  = 1'b1;
               hz.idex_flush  = 1'b1;
            end else if (load_use) begin
               pc_we          = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_flush  = 1'b1;
            end
         end
         S_MDU: begin
            if (mem_wait) begin
               pc_we          = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_we     = 1'b0;
               hz.exmem_we    = 1'b0;
               hz.memwb_flush = 1'b1;
            end else if (!hz.mdu_done) begin
               pc_we          = 1'b0;
               hz.ifid_we     = 1'b0;
               hz.idex_we     = 1'b0;
               hz.exmem_flush = 1'b1;
            end
         end
         default: begin
            pc_we          = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
            hz.memwb_flush = 1'b1;
         end
      endcase
   end

   assign hz.pc_we = pc_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_INIT;
         init_cnt    <= '0;
         mdu_tmr     <= '0;
         mdu_timeout <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (!mem_wait && hz.mdu_start) begin
                  state   <= S_MDU;
                  mdu_tmr <= '0;
               end
            end
            S_MDU: begin
               mdu_tmr <= mdu_tmr + 1'b1;
               if (mdu_go) begin
                  state <= S_RUN;
               end else if (mdu_last) begin
                  // Give up on the MDU; the pipeline resumes as normal.
                  state       <= S_RUN;
                  mdu_timeout <= 1'b1;
               end
            end
            default: begin
               if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                  state <= S_RUN;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (state != S_INIT && !pc_we
                   && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule
